// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: ALU result handshake bundle (out_parity present with ALU_RESULT_PARITY_EN)
interface alu_result_buffer_if #(parameter int N = 6);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] in_result;
  logic in_carry;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] out_data;
  logic out_zero;
  logic out_neg;
  logic out_carry;
`ifdef ALU_RESULT_PARITY_EN
  logic out_parity;
  modport master(output in_valid, in_result, in_carry, out_ready,
                 input in_ready, out_valid, out_data, out_zero, out_neg, out_carry, out_parity);
  modport slave(input in_valid, in_result, in_carry, out_ready,
                output in_ready, out_valid, out_data, out_zero, out_neg, out_carry, out_parity);
`else
  modport master(output in_valid, in_result, in_carry, out_ready,
                 input in_ready, out_valid, out_data, out_zero, out_neg, out_carry);
  modport slave(input in_valid, in_result, in_carry, out_ready,
                output in_ready, out_valid, out_data, out_zero, out_neg, out_carry);
`endif
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: 2-entry registered FIFO of ALU results with flags and accept counter (ALU_RESULT_PARITY_EN adds out_parity)
module alu_result_buffer #(
  parameter int N = 6,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_result_buffer_if.slave bus,
  output logic [CNT_W-1:0] acc_cnt
);
`ifdef ALU_RESULT_PARITY_EN
  localparam int EW = N + 4;
`else
  localparam int EW = N + 3;
`endif
  typedef enum logic [1:0] {INIT, EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [EW-1:0] head, tail, head_n, tail_n, cap;
  logic rdy, vld, push, pop;
  assign push = bus.in_valid & rdy;
  assign pop = vld & bus.out_ready;
`ifdef ALU_RESULT_PARITY_EN
  assign cap = {^bus.in_result, bus.in_carry, bus.in_result[N-1], bus.in_result == '0, bus.in_result};
  assign bus.out_parity = head[N+3];
`else
  assign cap = {bus.in_carry, bus.in_result[N-1], bus.in_result == '0, bus.in_result};
`endif
  assign bus.in_ready = rdy;
  assign bus.out_valid = vld;
  assign bus.out_data = head[N-1:0];
  assign bus.out_zero = head[N];
  assign bus.out_neg = head[N+1];
  assign bus.out_carry = head[N+2];
  // next occupancy and entry contents; head is left untouched when draining to EMPTY
  always_comb begin
    state_n = state;
    head_n = head;
    tail_n = tail;
    case (state)
      INIT: state_n = EMPTY;
      EMPTY: if (push) begin
        state_n = ONE;
        head_n = cap;
      end
      ONE: if (push && pop) head_n = cap;
        else if (push) begin
          state_n = FULL;
          tail_n = cap;
        end else if (pop) state_n = EMPTY;
      FULL: if (pop) begin
        state_n = ONE;
        head_n = tail;
      end
      default: state_n = INIT;
    endcase
  end
  // state, entries, registered handshake flags and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      head <= '0;
      tail <= '0;
      rdy <= 1'b0;
      vld <= 1'b0;
      acc_cnt <= '0;
    end else begin
      state <= state_n;
      head <= head_n;
      tail <= tail_n;
      rdy <= state_n == EMPTY || state_n == ONE;
      vld <= state_n == ONE || state_n == FULL;
      acc_cnt <= push && acc_cnt != '1 ? acc_cnt + 1'b1 : acc_cnt;
    end
  end
endmodule
